// File: rtl/mem_if_pkg.sv
// Shared types and constants for the memory bus interface (mem_bus_if).
// The optional access timeout is enabled with the MEM_TIMEOUT_EN macro.
package mem_if_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        DONE    = 2'd3
    } mem_state_e;

    localparam int          ADDR_W             = 20;
    localparam int          DATA_W             = 16;
    localparam logic [3:0]  MEM_TIMEOUT_CYCLES = 4'd15;

endpackage

// File: rtl/reg16.sv
// 16-bit register with synchronous active-high reset and load enable; used for MAR and MDR.
module reg16
    import mem_if_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ld,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // Storage: reset clears, load captures d, otherwise hold.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            q <= {DATA_W{1'b0}};
        end else if (ld) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/mem_bus_if.sv
// MAR/MDR datapath and memory access FSM with registered Moore strobes.
// Optional wait-state timeout with sticky Mem_Err is enabled by defining MEM_TIMEOUT_EN.
module mem_bus_if
    import mem_if_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] BUS,
    input  logic              LD_MAR,
    input  logic              LD_MDR,
    input  logic              MIO_EN,
    input  logic              Mem_Start,
    input  logic              Mem_Rd_Wr,
    input  logic [DATA_W-1:0] Data_from_SRAM,
    input  logic              Mem_Ready,
    output logic [DATA_W-1:0] MAR,
    output logic [DATA_W-1:0] MDR,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] Data_to_SRAM,
    output logic              Mem_CE,
    output logic              Mem_OE,
    output logic              Mem_WE,
    output logic              R,
    output logic              Busy,
    output logic              Mem_Err
);

    mem_state_e        state_r;
    logic              mem_ce_r;
    logic              mem_oe_r;
    logic              mem_we_r;
    logic              r_r;
    logic              busy_r;

    logic              idle_s;
    logic              waiting_s;
    logic              timeout_hit_s;
    logic              mar_ld_s;
    logic              mdr_ld_s;
    logic [DATA_W-1:0] mdr_d_s;
    logic [DATA_W-1:0] mar_s;
    logic [DATA_W-1:0] mdr_s;

    assign idle_s    = (state_r == IDLE);
    assign waiting_s = (state_r == RD_WAIT) || (state_r == WR_WAIT);

    // Register loads are only honoured in IDLE; the read capture is the sole MDR update while busy.
    assign mar_ld_s = idle_s && LD_MAR;
    assign mdr_ld_s = (idle_s && LD_MDR && !MIO_EN) || ((state_r == RD_WAIT) && Mem_Ready);
    assign mdr_d_s  = (state_r == RD_WAIT) ? Data_from_SRAM : BUS;

    reg16 u_mar (
        .Clk   (Clk),
        .Reset (Reset),
        .ld    (mar_ld_s),
        .d     (BUS),
        .q     (mar_s)
    );

    reg16 u_mdr (
        .Clk   (Clk),
        .Reset (Reset),
        .ld    (mdr_ld_s),
        .d     (mdr_d_s),
        .q     (mdr_s)
    );

`ifdef MEM_TIMEOUT_EN
    logic [3:0] wait_cnt_r;
    logic       mem_err_r;

    assign timeout_hit_s = (wait_cnt_r == (MEM_TIMEOUT_CYCLES - 4'd1));

    // Wait-cycle counter: restarts on every entry into a wait state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wait_cnt_r <= 4'd0;
        end else if (waiting_s && !Mem_Ready && !timeout_hit_s) begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
        end else begin
            wait_cnt_r <= 4'd0;
        end
    end

    // Sticky timeout flag: set on an expired wait, cleared by the next accepted start.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            mem_err_r <= 1'b0;
        end else if (idle_s && Mem_Start) begin
            mem_err_r <= 1'b0;
        end else if (waiting_s && !Mem_Ready && timeout_hit_s) begin
            mem_err_r <= 1'b1;
        end else begin
            mem_err_r <= mem_err_r;
        end
    end

    assign Mem_Err = mem_err_r;
`else
    assign timeout_hit_s = 1'b0;
    assign Mem_Err       = 1'b0;
`endif

    // Access FSM; strobes are registered together with the next state so they decode the state exactly.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r  <= IDLE;
            mem_ce_r <= 1'b0;
            mem_oe_r <= 1'b0;
            mem_we_r <= 1'b0;
            r_r      <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            mem_ce_r <= 1'b0;
            mem_oe_r <= 1'b0;
            mem_we_r <= 1'b0;
            r_r      <= 1'b0;
            busy_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (Mem_Start && Mem_Rd_Wr) begin
                        state_r  <= WR_WAIT;
                        mem_ce_r <= 1'b1;
                        mem_we_r <= 1'b1;
                        busy_r   <= 1'b1;
                    end else if (Mem_Start) begin
                        state_r  <= RD_WAIT;
                        mem_ce_r <= 1'b1;
                        mem_oe_r <= 1'b1;
                        busy_r   <= 1'b1;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                RD_WAIT, WR_WAIT: begin
                    busy_r <= 1'b1;
                    if (Mem_Ready || timeout_hit_s) begin
                        state_r <= DONE;
                        r_r     <= 1'b1;
                    end else begin
                        state_r  <= state_r;
                        mem_ce_r <= 1'b1;
                        mem_oe_r <= (state_r == RD_WAIT);
                        mem_we_r <= (state_r == WR_WAIT);
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign MAR          = mar_s;
    assign MDR          = mdr_s;
    assign ADDR         = {{(ADDR_W - DATA_W){1'b0}}, mar_s};
    assign Data_to_SRAM = mdr_s;
    assign Mem_CE       = mem_ce_r;
    assign Mem_OE       = mem_oe_r;
    assign Mem_WE       = mem_we_r;
    assign R            = r_r;
    assign Busy         = busy_r;

endmodule

// File: tb/tb_mem_bus_if.sv
// Directed self-checking bench for mem_bus_if; the timeout scenario follows MEM_TIMEOUT_EN.
module tb_mem_bus_if;

    logic        Clk;
    logic        Reset;
    logic [15:0] BUS;
    logic        LD_MAR;
    logic        LD_MDR;
    logic        MIO_EN;
    logic        Mem_Start;
    logic        Mem_Rd_Wr;
    logic [15:0] Data_from_SRAM;
    logic        Mem_Ready;
    logic [15:0] MAR;
    logic [15:0] MDR;
    logic [19:0] ADDR;
    logic [15:0] Data_to_SRAM;
    logic        Mem_CE;
    logic        Mem_OE;
    logic        Mem_WE;
    logic        R;
    logic        Busy;
    logic        Mem_Err;

    int checks_r;
    int errors_r;

    mem_bus_if dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .BUS            (BUS),
        .LD_MAR         (LD_MAR),
        .LD_MDR         (LD_MDR),
        .MIO_EN         (MIO_EN),
        .Mem_Start      (Mem_Start),
        .Mem_Rd_Wr      (Mem_Rd_Wr),
        .Data_from_SRAM (Data_from_SRAM),
        .Mem_Ready      (Mem_Ready),
        .MAR            (MAR),
        .MDR            (MDR),
        .ADDR           (ADDR),
        .Data_to_SRAM   (Data_to_SRAM),
        .Mem_CE         (Mem_CE),
        .Mem_OE         (Mem_OE),
        .Mem_WE         (Mem_WE),
        .R              (R),
        .Busy           (Busy),
        .Mem_Err        (Mem_Err)
    );

    // 100 MHz clock.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_r = checks_r + 1;
        if (obs !== exp) begin
            errors_r = errors_r + 1;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled 1 ns after the rising edge.
    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        LD_MAR    = 1'b0;
        LD_MDR    = 1'b0;
        MIO_EN    = 1'b0;
        Mem_Start = 1'b0;
        Mem_Rd_Wr = 1'b0;
        Mem_Ready = 1'b0;
    endtask

    int we_cnt;
    int oe_cnt;
    int r_cnt;

    initial begin
        checks_r       = 0;
        errors_r       = 0;
        BUS            = 16'h0000;
        Data_from_SRAM = 16'h0000;
        clear_inputs();
        Reset = 1'b1;
        cyc();
        cyc();
        check_val("rst_mar",  {16'h0, MAR}, 32'h0);
        check_val("rst_mdr",  {16'h0, MDR}, 32'h0);
        check_val("rst_ctl",  {26'h0, Mem_CE, Mem_OE, Mem_WE, R, Busy, Mem_Err}, 32'h0);
        Reset = 1'b0;

        // Load then read.
        BUS = 16'h3001; LD_MAR = 1'b1;
        cyc();
        LD_MAR = 1'b0;
        check_val("rd_mar",  {16'h0, MAR}, 32'h3001);
        check_val("rd_addr", {12'h0, ADDR}, 32'h03001);
        Mem_Start = 1'b1; Mem_Rd_Wr = 1'b0;
        cyc();
        Mem_Start = 1'b0;
        check_val("rd_wait", {27'h0, Mem_CE, Mem_OE, Mem_WE, R, Busy}, {27'h0, 5'b11001});
        Mem_Ready = 1'b1; Data_from_SRAM = 16'hBEEF;
        cyc();
        Mem_Ready = 1'b0;
        check_val("rd_done", {27'h0, Mem_CE, Mem_OE, Mem_WE, R, Busy}, {27'h0, 5'b00011});
        check_val("rd_mdr",  {16'h0, MDR}, 32'hBEEF);
        cyc();
        check_val("rd_idle", {30'h0, R, Busy}, 32'h0);

        // Mem_Ready in IDLE must be ignored.
        Mem_Ready = 1'b1; Data_from_SRAM = 16'h7777;
        cyc();
        Mem_Ready = 1'b0;
        check_val("idle_rdy", {15'h0, Busy, MDR}, {17'h0, 15'h0} | 32'hBEEF);

        // Write: MAR load, then MDR load coinciding with the start.
        BUS = 16'h0010; LD_MAR = 1'b1;
        cyc();
        LD_MAR = 1'b0;
        BUS = 16'h1234; LD_MDR = 1'b1; MIO_EN = 1'b0; Mem_Start = 1'b1; Mem_Rd_Wr = 1'b1;
        cyc();
        clear_inputs();
        BUS = 16'h0000;
        check_val("wr_data", {16'h0, Data_to_SRAM}, 32'h1234);
        check_val("wr_addr", {12'h0, ADDR}, 32'h00010);
        we_cnt = 0; r_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (Mem_WE) we_cnt++;
            if (Mem_OE) we_cnt += 100;
            if (R) r_cnt++;
            Mem_Ready = (i == 2);
            cyc();
        end
        Mem_Ready = 1'b0;
        check_val("wr_we_cycles", we_cnt, 32'd3);
        check_val("wr_r_pulses",  r_cnt,  32'd1);

        // LD_MDR with MIO_EN=1 in IDLE is ignored.
        BUS = 16'h5555; LD_MDR = 1'b1; MIO_EN = 1'b1;
        cyc();
        clear_inputs();
        check_val("mio_ignore", {16'h0, MDR}, 32'h1234);

        // Busy lockout during RD_WAIT.
        Mem_Start = 1'b1; Mem_Rd_Wr = 1'b0;
        cyc();
        clear_inputs();
        BUS = 16'hFFFF; LD_MAR = 1'b1; LD_MDR = 1'b1; Mem_Start = 1'b1;
        cyc();
        clear_inputs();
        check_val("lock_mar", {16'h0, MAR}, 32'h0010);
        check_val("lock_mdr", {16'h0, MDR}, 32'h1234);
        check_val("lock_oe",  {31'h0, Mem_OE}, 32'h1);
        r_cnt = 0; oe_cnt = 0;
        Data_from_SRAM = 16'h0A0A;
        for (int i = 0; i < 6; i++) begin
            if (R) r_cnt++;
            if (Mem_OE || Mem_WE) oe_cnt++;
            Mem_Ready = (i == 0);
            cyc();
        end
        Mem_Ready = 1'b0;
        check_val("lock_r_pulses", r_cnt, 32'd1);
        check_val("lock_strobes",  oe_cnt, 32'd1);
        check_val("lock_mdr_cap",  {16'h0, MDR}, 32'h0A0A);

        // Reset mid-read.
        Mem_Start = 1'b1; Mem_Rd_Wr = 1'b0;
        cyc();
        Mem_Start = 1'b0;
        check_val("rst_mid_pre", {31'h0, Mem_OE}, 32'h1);
        Reset = 1'b1; Mem_Ready = 1'b1;
        cyc();
        Reset = 1'b0; Mem_Ready = 1'b0;
        check_val("rst_mid_ctl", {26'h0, Mem_CE, Mem_OE, Mem_WE, R, Busy, Mem_Err}, 32'h0);
        check_val("rst_mid_reg", {MAR, MDR}, 32'h0);
        r_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (R || Busy) r_cnt++;
            cyc();
        end
        check_val("rst_mid_quiet", r_cnt, 32'd0);

        // Read with Mem_Ready never asserted.
        BUS = 16'h4321; LD_MDR = 1'b1; MIO_EN = 1'b0;
        cyc();
        clear_inputs();
        Mem_Start = 1'b1; Mem_Rd_Wr = 1'b0;
        cyc();
        Mem_Start = 1'b0;
        oe_cnt = 0; r_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (Mem_OE) oe_cnt++;
            if (R) r_cnt++;
            cyc();
        end
`ifdef MEM_TIMEOUT_EN
        check_val("to_oe_cycles", oe_cnt, 32'd15);
        check_val("to_r_pulses",  r_cnt,  32'd1);
        check_val("to_err",       {31'h0, Mem_Err}, 32'h1);
        check_val("to_mdr",       {16'h0, MDR}, 32'h4321);
        check_val("to_busy",      {31'h0, Busy}, 32'h0);
        Mem_Start = 1'b1; Mem_Rd_Wr = 1'b0;
        cyc();
        Mem_Start = 1'b0;
        check_val("to_err_clr", {31'h0, Mem_Err}, 32'h0);
        Mem_Ready = 1'b1;
        cyc();
        Mem_Ready = 1'b0;
        cyc();
`else
        check_val("nto_oe_cycles", oe_cnt, 32'd20);
        check_val("nto_r_pulses",  r_cnt,  32'd0);
        check_val("nto_busy",      {30'h0, Busy, Mem_Err}, 32'h2);
        check_val("nto_mdr",       {16'h0, MDR}, 32'h4321);
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule

// File: doc/mem_bus_if.md
MEM_BUS_IF -- requirements
Module: mem_bus_if

Interface
REQ-001 The block SHALL use one clock, Clk, and a synchronous, active-high reset, Reset.
REQ-002 Clk  input  1  system clock; all state changes on its rising edge.
REQ-003 Reset  input  1  synchronous active-high reset.
REQ-004 BUS  input  16  shared datapath bus; the value driven by the gated source this cycle.
REQ-005 LD_MAR  input  1  load MAR from BUS.
REQ-006 LD_MDR  input  1  load MDR; source selected by MIO_EN.
REQ-007 MIO_EN  input  1  MDR source select: 0 = BUS, 1 = memory read data.
REQ-008 Mem_Start  input  1  one-cycle request to start a memory access.
REQ-009 Mem_Rd_Wr  input  1  access type, sampled with Mem_Start: 0 = read, 1 = write.
REQ-010 Data_from_SRAM  input  16  memory read data.
REQ-011 Mem_Ready  input  1  memory completion strobe.
REQ-012 MAR  output  16  memory address register.
REQ-013 MDR  output  16  memory data register.
REQ-014 ADDR  output  20  memory address, {4'b0, MAR}.
REQ-015 Data_to_SRAM  output  16  write data; equals MDR.
REQ-016 Mem_CE, Mem_OE, Mem_WE  output  1 each  active-high memory chip enable, output enable and write enable.
REQ-017 R  output  1  one-cycle access-complete pulse.
REQ-018 Busy  output  1  high whenever the state is not IDLE.
REQ-019 Mem_Err  output  1  sticky access-timeout flag.

Function
REQ-020 The FSM SHALL have four states: IDLE, RD_WAIT, WR_WAIT and DONE.
REQ-021 IDLE transitions:
  - Mem_Start with Mem_Rd_Wr=0 -> RD_WAIT.
  - Mem_Start with Mem_Rd_Wr=1 -> WR_WAIT.
  - Otherwise the FSM stays in IDLE.
REQ-022 In IDLE: LD_MAR loads MAR<=BUS; LD_MDR with MIO_EN=0 loads MDR<=BUS; LD_MDR with MIO_EN=1 is ignored.
REQ-023 When LD_MAR/LD_MDR coincide with Mem_Start, the loads complete first and the access uses the newly loaded MAR/MDR from the next cycle on.
REQ-024 RD_WAIT: Mem_CE=1, Mem_OE=1. On Mem_Ready=1, MDR<=Data_from_SRAM and the FSM moves to DONE.
REQ-025 WR_WAIT: Mem_CE=1, Mem_WE=1, Data_to_SRAM=MDR. On Mem_Ready=1 the FSM moves to DONE.
REQ-026 DONE: R=1 for exactly one cycle, then the FSM returns to IDLE unconditionally.
REQ-027 Minimum latency: Mem_Start at cycle n, Mem_Ready at cycle n+1 -> R=1 at cycle n+2.
REQ-028 While Busy=1, the block SHALL ignore Mem_Start, LD_MAR and LD_MDR; MAR and MDR stay stable except for the read capture in REQ-024.
REQ-029 Mem_Ready while in IDLE or DONE SHALL be ignored.
REQ-030 Memory strobes SHALL be decoded from the state only (Moore outputs); all of them are 0 in IDLE and DONE.

Reset
REQ-031 Reset=1 SHALL force, at the next rising edge: state=IDLE, MAR=0, MDR=0, R=0, Busy=0, Mem_Err=0, all memory strobes 0.
REQ-032 Reset asserted mid-access SHALL abort the access; strobes drop in the following cycle and no R pulse is generated.
REQ-033 Reset SHALL take priority over every other input.

Configuration
REQ-034 Timeout is controlled by the macro MEM_TIMEOUT_EN.
REQ-035 With MEM_TIMEOUT_EN defined:
  - A 4-bit counter counts cycles spent in RD_WAIT/WR_WAIT.
  - After 15 wait cycles without Mem_Ready, the FSM goes to DONE with MDR unchanged and sets Mem_Err=1.
  - Mem_Err clears on the next accepted Mem_Start.
REQ-036 Without MEM_TIMEOUT_EN, the wait states SHALL wait indefinitely and Mem_Err SHALL be tied to 0; the port remains.

Structure
REQ-037 Shared package mem_if_pkg SHALL hold:
  - the state enum (IDLE, RD_WAIT, WR_WAIT, DONE);
  - MEM_TIMEOUT_CYCLES=15;
  - ADDR_W=20;
  - DATA_W=16.
REQ-038 MAR and MDR SHALL each be an instance of one sub-module, reg16: a 16-bit register with synchronous Reset and load enable.

Verification
REQ-039 Load then read: BUS=16'h3001 with LD_MAR; Mem_Start with Mem_Rd_Wr=0; Mem_Ready one cycle later with Data_from_SRAM=16'hBEEF -> ADDR=20'h03001, Mem_OE high for 1 cycle, MDR=16'hBEEF, R pulses at n+2.
REQ-040 Write: MDR<=16'h1234 via BUS, MAR=16'h0010; Mem_Start with Mem_Rd_Wr=1; Mem_Ready after 3 cycles -> Mem_WE high for exactly 3 cycles, Data_to_SRAM=16'h1234, then a single R pulse.
REQ-041 Busy lockout: during RD_WAIT, pulse LD_MAR with BUS=16'hFFFF and Mem_Start -> MAR unchanged, no second access, exactly one R pulse.
REQ-042 Reset mid-read: Reset during RD_WAIT -> next cycle all outputs 0, state IDLE, no R pulse.
REQ-043 MEM_TIMEOUT_EN: read with Mem_Ready never asserted -> DONE after 15 wait cycles, Mem_Err=1, MDR unchanged. Without the macro, the FSM stays in RD_WAIT indefinitely.
